// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect scheduler for the five-stage core: merges stage stall
// requests and picks one prioritised redirect, parking it while the PC is held.
module pipeline_ctrl #(
  parameter int unsigned      PC_W     = 64,
  parameter logic [PC_W-1:0]  START_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall_req,
  input  logic            id_stall_req,
  input  logic            mem_stall_req,
  input  logic            id_redir_valid,
  input  logic [PC_W-1:0] id_redir_pc,
  input  logic            ex_redir_valid,
  input  logic [PC_W-1:0] ex_redir_pc,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_pc,
  output logic [4:0]      stall_ctrl,
  output logic [2:0]      flush,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic            pend_busy
);

  if (START_PC[0] != 1'b0) begin : g_start_pc_check
    $error("pipeline_ctrl: START_PC must be at least 2-byte aligned");
  end

  // Encoding doubles as the source class, so a larger value means higher priority.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PEND_ID   = 2'd1,
    PEND_EX   = 2'd2,
    PEND_TRAP = 2'd3
  } state_t;

  state_t          state, state_nx;
  state_t          live_cls, sel_cls;
  logic [PC_W-1:0] pend_pc, pend_pc_nx;
  logic [PC_W-1:0] live_pc, sel_pc;
  logic            live_wins, issue, kill_id, id_eff;
  logic [4:0]      stall_int;
  logic [2:0]      flush_int;

  always_comb begin
    live_cls = IDLE;
    live_pc  = '0;
    if (trap_valid) begin
      live_cls = PEND_TRAP;
      live_pc  = trap_pc;
    end else if (ex_redir_valid) begin
      live_cls = PEND_EX;
      live_pc  = ex_redir_pc;
    end else if (id_redir_valid) begin
      live_cls = PEND_ID;
      live_pc  = id_redir_pc;
    end

    // Live request beats the stored one when its class is equal or higher.
    live_wins = (live_cls != IDLE) && (live_cls >= state);
    sel_cls   = live_wins ? live_cls : state;
    sel_pc    = live_wins ? live_pc  : pend_pc;
    issue     = (sel_cls != IDLE) && !mem_stall_req && !if_stall_req;
    kill_id   = issue && ((sel_cls == PEND_EX) || (sel_cls == PEND_TRAP));
    id_eff    = id_stall_req && !kill_id;

    stall_int = '0;
    if (mem_stall_req) stall_int = stall_int | 5'b01111;
    if (id_eff)        stall_int = stall_int | 5'b00011;
    if (if_stall_req)  stall_int = stall_int | 5'b00001;
    // The PC must always be free to load an issued redirect target.
    if (issue)         stall_int[0] = 1'b0;

    flush_int = {1'b0, id_eff, if_stall_req};
    if (issue) begin
      case (sel_cls)
        PEND_TRAP: flush_int = flush_int | 3'b111;
        PEND_EX:   flush_int = flush_int | 3'b011;
        default:   flush_int = flush_int | 3'b001;
      endcase
    end

    state_nx   = state;
    pend_pc_nx = pend_pc;
    if (issue) begin
      state_nx = IDLE;
    end else if (live_wins) begin
      state_nx   = live_cls;
      pend_pc_nx = live_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend_pc <= '0;
    end else begin
      state   <= state_nx;
      pend_pc <= pend_pc_nx;
    end
  end

  assign stall_ctrl  = rst ? '0 : stall_int;
  assign flush       = rst ? '0 : flush_int;
  assign redir_valid = !rst && issue;
  assign redir_pc    = (!rst && issue) ? sel_pc : '0;
  assign pend_busy   = !rst && (state != IDLE);

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/redirect scheduler for the five-stage core. It collects stall requests from fetch, decode and memory, and redirect requests from decode (jumps), execute (branch resolution) and the trap unit. It produces the per-stage `stall_ctrl` vector, the pipeline-register flush vector and a single prioritised redirect to the PC register. A redirect that arrives while the PC is held is stored and issued on the first unstalled cycle, so no redirect is ever lost.

## Interface
Parameters:
- PC_W, 64, PC/redirect address width
- START_PC, 64'h8000_0000, reserved for trap default; not used in reset logic

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_stall_req  in  1  fetch not ready (instruction memory busy)
- id_stall_req  in  1  load-use hazard in decode
- mem_stall_req  in  1  data memory busy
- id_redir_valid  in  1  decode jump redirect request
- id_redir_pc  in  PC_W  decode target
- ex_redir_valid  in  1  execute branch mispredict redirect
- ex_redir_pc  in  PC_W  execute target
- trap_valid  in  1  trap/mret redirect
- trap_pc  in  PC_W  trap target
- stall_ctrl  out  5  hold per register; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB; 1 = hold
- flush  out  3  bubble insert; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM
- redir_valid  out  1  one-cycle redirect strobe to PC
- redir_pc  out  PC_W  redirect target, valid with redir_valid
- pend_busy  out  1  a redirect is stored (state != IDLE)

## Operation
- Stall masks are ORed together:
  - mem_stall_req gives 5'b01111.
  - id_stall_req gives 5'b00011 and forces flush[1], so a bubble enters ID/EX.
  - if_stall_req gives 5'b00001 and forces flush[0], so a bubble enters IF/ID.
- Suppression: id_stall_req is ignored in any cycle where an EX or TRAP redirect issues, because the stalled instruction is killed.
- Issue condition: at least one candidate exists and neither mem_stall_req nor if_stall_req is set.
- Candidates are the stored pending redirect and the live requests.
  - Priority: TRAP > EX > ID.
  - On equal source class, the live request wins over the pending one.
- Flush on issue:
  - ID: flush = 3'b001.
  - EX: flush = 3'b011.
  - TRAP: flush = 3'b111.
- Flush ORs with any stall-driven flush bits.
- State machine, 2-bit: IDLE, PEND_ID, PEND_EX, PEND_TRAP; holds the stored pc register.
  - From IDLE: a live request in a non-issue cycle goes to PEND_<highest live source> and stores its pc.
  - From PEND_ID: live EX or TRAP in a non-issue cycle replaces it (state and pc). A live ID replaces the pc and stays PEND_ID.
  - From PEND_EX: live TRAP replaces it. Live EX refreshes the pc. Live ID is ignored, since it is wrong-path.
  - From PEND_TRAP: only live TRAP refreshes the pc. EX and ID are ignored.
  - Any PEND_* state returns to IDLE in an issue cycle.
  - In an issue cycle, live requests not selected are discarded. They are younger or equal and are killed by the flush.
- Outputs stall_ctrl, flush, redir_valid and redir_pc are combinational from inputs and state. The state and pending pc are registered.

## Timing
- Reset: state IDLE, pending pc 0. All outputs are 0 while rst is high, regardless of inputs.
- Live redirect with no stall: redir_valid is high in the same cycle (0-cycle latency), and the PC loads the target at the next edge.
- Pending redirect: issued in the first cycle where mem_stall_req and if_stall_req are both low; state is IDLE at the following edge.
- redir_valid is never high on two consecutive cycles from the same stored entry.
- rst asserted mid-pending: the entry is discarded and no redirect is issued after release.
- stall_ctrl[0] = 0 whenever redir_valid = 1.
- The suppressed id_stall_req does not hold the PC in an issue cycle.

## Test plan
- Reset, then all inputs 0 -> stall_ctrl=0, flush=0, redir_valid=0, pend_busy=0.
- ex_redir_valid=1, ex_redir_pc=0x8000_0100, no stalls -> same cycle: redir_valid=1, redir_pc=0x8000_0100, flush=3'b011, stall_ctrl=0.
- mem_stall_req high for 3 cycles with id_redir 0x8000_0040 in cycle 1 -> stall_ctrl=5'b01111 and pend_busy=1 in cycles 2-3. Cycle 4: mem_stall_req low, redir_valid=1, redir_pc=0x8000_0040, flush=3'b001.
- PEND_ID (0x40), then ex_redir 0x200 during the stall, then id_redir 0x80 during the stall -> on release redir_pc=0x200, flush=3'b011, exactly one strobe.
- id_stall_req=1 together with ex_redir_valid=1 -> stall_ctrl=0, redir_valid=1, flush=3'b011. Then id_stall_req alone -> stall_ctrl=5'b00011, flush=3'b010.
- PEND_TRAP (0x8000_0004) pending, rst pulsed for 1 cycle, stalls released -> redir_valid stays 0, pend_busy=0.
